// File: rtl/elevator_goal_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_goal_scheduler
//
// Latches hall/car call requests for N_FLOORS floors and runs a LOOK scheduler
// (IDLE / UP / DOWN). It produces a registered goal floor for the motion
// controller. A request is cleared when the car serves it: the car must be
// stopped, aligned, and at a valid floor.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous reset, active low; overrides every other input
//   call_req     one bit per floor; a 1 sets the pending bit (level or pulse)
//   floor        current car floor index (>= N_FLOORS is treated as invalid)
//   at_floor     car is aligned with 'floor'
//   move_handler car is moving; goal, goal_valid and state are frozen
//   pending      latched outstanding requests (button LEDs)
//   gf           registered goal floor
//   goal_valid   gf holds a live target
//   dir_up       1 = travelling UP, 0 = DOWN or IDLE
//   served       one-cycle pulse, one cycle after a request is cleared
// -----------------------------------------------------------------------------
module elevator_goal_scheduler #(
    parameter int N_FLOORS = 3,
    parameter int FW       = 2,
    parameter int TIE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic [FW-1:0]       floor,
    input  logic                at_floor,
    input  logic                move_handler,
    output logic [N_FLOORS-1:0] pending,
    output logic [FW-1:0]       gf,
    output logic                goal_valid,
    output logic                dir_up,
    output logic                served
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic [FW:0] N_EXT = (FW+1)'(N_FLOORS);

    state_t              state_reg, state_next;
    logic [N_FLOORS-1:0] pending_reg, pending_next;
    logic [FW-1:0]       gf_reg, gf_next;
    logic                gv_reg, gv_next;
    logic                served_reg;

    logic [FW:0]         floor_ext;
    logic                floor_ok;
    logic [N_FLOORS-1:0] req_all;
    logic [N_FLOORS-1:0] at_mask;
    logic [N_FLOORS-1:0] above;
    logic [N_FLOORS-1:0] below;
    logic                serve;
    logic                here_pend;
    logic                any_above, any_below;
    logic [FW-1:0]       lowest_above, highest_below;
    logic [FW:0]         dist_up, dist_dn;

    assign floor_ext = {1'b0, floor};
    assign floor_ok  = (floor_ext < N_EXT);
    assign req_all   = pending_reg | call_req;

    // One-hot decode of the current floor plus above/below masks of the
    // post-update request set. An invalid floor decodes to all zeros.
    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor_masks
        assign at_mask[gi] = (floor_ext == (FW+1)'(gi));
        assign above[gi]   = pending_next[gi] && ((FW+1)'(gi) > floor_ext);
        assign below[gi]   = pending_next[gi] && ((FW+1)'(gi) < floor_ext);
    end

    // The serve test looks at the request set that includes this cycle's
    // calls. A call at the floor where the car stands stopped is cleared in
    // the same cycle, so its LED never lights, and it still produces a
    // served pulse.
    assign serve        = !move_handler && at_floor && floor_ok && |(req_all & at_mask);
    assign pending_next = req_all & ~(serve ? at_mask : '0);

    assign here_pend = |(pending_next & at_mask);
    assign any_above = |above;
    assign any_below = |below;

    // Nearest request on each side of the car.
    always_comb begin
        lowest_above  = '0;
        highest_below = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (above[i]) lowest_above = FW'(i);
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (below[i]) highest_below = FW'(i);
        end
    end

    assign dist_up = {1'b0, lowest_above} - floor_ext;
    assign dist_dn = floor_ext - {1'b0, highest_below};

    // LOOK scheduler. It runs on the post-update request set, so a new call
    // shows up in gf one cycle after call_req. It is frozen while the car
    // moves or while the floor input is out of range.
    always_comb begin
        state_next = state_reg;
        gf_next    = gf_reg;
        gv_next    = gv_reg;
        if (!move_handler && floor_ok) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (here_pend) begin
                        gf_next    = floor;
                        gv_next    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (any_above && any_below) begin
                        gv_next = 1'b1;
                        if ((dist_up < dist_dn) || ((dist_up == dist_dn) && (TIE_LOW == 0))) begin
                            gf_next    = lowest_above;
                            state_next = ST_UP;
                        end else begin
                            gf_next    = highest_below;
                            state_next = ST_DOWN;
                        end
                    end else if (any_above) begin
                        gf_next    = lowest_above;
                        gv_next    = 1'b1;
                        state_next = ST_UP;
                    end else if (any_below) begin
                        gf_next    = highest_below;
                        gv_next    = 1'b1;
                        state_next = ST_DOWN;
                    end else begin
                        gv_next    = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
                ST_UP: begin
                    if (any_above) begin
                        gf_next = lowest_above;
                        gv_next = 1'b1;
                    end else if (any_below) begin
                        gf_next    = highest_below;
                        gv_next    = 1'b1;
                        state_next = ST_DOWN;
                    end else begin
                        gv_next    = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
                ST_DOWN: begin
                    if (any_below) begin
                        gf_next = highest_below;
                        gv_next = 1'b1;
                    end else if (any_above) begin
                        gf_next    = lowest_above;
                        gv_next    = 1'b1;
                        state_next = ST_UP;
                    end else begin
                        gv_next    = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    gv_next    = 1'b0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
            gf_reg      <= '0;
            gv_reg      <= 1'b0;
            served_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            gf_reg      <= gf_next;
            gv_reg      <= gv_next;
            served_reg  <= serve;
        end
    end

    assign pending    = pending_reg;
    assign gf         = gf_reg;
    assign goal_valid = gv_reg;
    assign dir_up     = (state_reg == ST_UP);
    assign served     = served_reg;

endmodule
